// File: rtl/clkdiv_pkg.sv
`default_nettype none
`timescale 1ns/100ps
// +--------------------------------------------------------------------+
// | clkdiv_pkg: shared constants and next-count helper for the         |
// | divide-by-3 clock generator.                          Rev 1.0      |
// +--------------------------------------------------------------------+
package clkdiv_pkg;

    localparam int         CLKDIV3_RATIO = 3;
    localparam logic [1:0] CLKDIV3_MAX   = 2'(CLKDIV3_RATIO - 1);

    // Anything at or above the terminal count wraps to 0, so a corrupted 3 self-clears.
    function automatic logic [1:0] clkdiv3_next(input logic [1:0] cnt);
        return (cnt >= CLKDIV3_MAX) ? 2'd0 : cnt + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_divider_by3_counter_if.sv
`default_nettype none
`timescale 1ns/100ps
// +--------------------------------------------------------------------+
// | clk_divider_by3_counter_if: output bundle of the divide-by-3       |
// | generator (count, terminal strobe, divided clock).    Rev 1.0      |
// +--------------------------------------------------------------------+
interface clk_divider_by3_counter_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] o_count;
    logic             o_count_end;
    logic             o_div3_clk;

    modport master (
        output o_count,
        output o_count_end,
        output o_div3_clk
    );

    modport slave (
        input o_count,
        input o_count_end,
        input o_div3_clk
    );
endinterface
`default_nettype wire

// File: rtl/clkdiv_negedge_ff.sv
`default_nettype none
`timescale 1ns/100ps
// +--------------------------------------------------------------------+
// | clkdiv_negedge_ff: 1-bit falling-edge flop, async active-low clear.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module clkdiv_negedge_ff (
    input  wire  clk,
    input  wire  resetn,
    input  wire  d_i,
    output logic q_o
);
    logic q_q;

    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;
endmodule
`default_nettype wire

// File: rtl/clk_divider_by3_counter.sv
`default_nettype none
`timescale 1ns/100ps
// +--------------------------------------------------------------------+
// | clk_divider_by3_counter: modulo-3 counter with terminal strobe and |
// | divided clock. CLKDIV3_DUTY50_EN selects 50% duty, else 33%.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module clk_divider_by3_counter
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  wire                       clk,
    input  wire                       resetn,
    clk_divider_by3_counter_if.master bus
);
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       div_p_q;
    logic       div_p_d;
    logic       count_end;

    assign count_end = (cnt_q == CLKDIV3_MAX);

    always_comb begin
        cnt_d   = clkdiv3_next(cnt_q);
        div_p_d = count_end;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= 2'd0;
            div_p_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_p_q <= div_p_d;
        end
    end

    assign bus.o_count     = WIDTH'(cnt_q);
    assign bus.o_count_end = count_end;

`ifdef CLKDIV3_DUTY50_EN
    logic div_n_q;

    // Half-cycle delayed copy stretches the high phase from 1 to 1.5 cycles.
    clkdiv_negedge_ff u_div_n (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (div_p_q),
        .q_o    (div_n_q)
    );

    assign bus.o_div3_clk = div_p_q | div_n_q;
`else
    assign bus.o_div3_clk = div_p_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_clk_divider_by3_counter.sv
`default_nettype none
`timescale 1ns/100ps
// +--------------------------------------------------------------------+
// | tb_clk_divider_by3_counter: scoreboard bench for the divide-by-3   |
// | generator; follows CLKDIV3_DUTY50_EN like the RTL.     Rev 1.0     |
// +--------------------------------------------------------------------+
module tb_clk_divider_by3_counter;

    localparam int TB_W = 4;

`ifdef CLKDIV3_DUTY50_EN
    localparam int HIGH_TENTHS = 30;
`else
    localparam int HIGH_TENTHS = 20;
`endif

    typedef struct packed {
        logic [TB_W-1:0] cnt;
        logic            ce;
        logic            dv;
    } exp_t;

    logic  clk    = 1'b0;
    logic  resetn = 1'b0;
    bit    mon_on = 1'b1;
    int    k      = 0;
    int    n_chk  = 0;
    int    n_err  = 0;
    exp_t  sb_q[$];
    realtime t_rise = 0.0, t_rise_prev = 0.0, t_fall = 0.0;

    clk_divider_by3_counter_if #(.WIDTH(TB_W)) bus ();

    clk_divider_by3_counter #(.WIDTH(TB_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #1 clk = ~clk;

    task automatic chk_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // kk = number of rising edges seen with resetn high; half 0 = after rise, 1 = after fall.
    function automatic exp_t model(input int kk, input bit half);
        exp_t e;
        int   c;
        e = '0;
        if (kk > 0) begin
            c     = kk % 3;
            e.cnt = TB_W'(c);
            e.ce  = (c == 2);
`ifdef CLKDIV3_DUTY50_EN
            e.dv  = (kk >= 3) && ((c == 0) || (!half && c == 1 && kk >= 4));
`else
            e.dv  = (kk >= 3) && (c == 0);
`endif
        end
        return e;
    endfunction

    function automatic bit mid_ok(input int kk);
`ifdef CLKDIV3_DUTY50_EN
        return (kk >= 4) && (kk % 3 == 1);
`else
        return (kk >= 3) && (kk % 3 == 0);
`endif
    endfunction

    task automatic pop_cmp(input string half_tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk_value({"sb_empty_", half_tag}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk_value({"count_", half_tag},     32'(bus.o_count),     32'(e.cnt));
            chk_value({"count_end_", half_tag}, 32'(bus.o_count_end), 32'(e.ce));
            chk_value({"div3_clk_", half_tag},  32'(bus.o_div3_clk),  32'(e.dv));
        end
    endtask

    always @(posedge clk) begin
        if (mon_on) begin
            #0.5 pop_cmp("rise");
            #1.0 pop_cmp("fall");
        end
    end

    always @(posedge bus.o_div3_clk) begin
        t_rise_prev = t_rise;
        t_rise      = $realtime;
    end

    always @(negedge bus.o_div3_clk) t_fall = $realtime;

    // Called between a falling and the next rising edge; sets up that rising edge.
    task automatic step(input logic rst_val, input bit mid_rst);
        int kn;
        resetn = rst_val;
        kn     = rst_val ? k + 1 : 0;
        sb_q.push_back(model(kn, 1'b0));
        sb_q.push_back(model(mid_rst ? 0 : kn, 1'b1));
        k = kn;
        if (mid_rst) begin
            @(posedge clk);
            #0.7 resetn = 1'b0;
            #0.1;
            chk_value("mid_rst_count",     32'(bus.o_count),     32'd0);
            chk_value("mid_rst_count_end", 32'(bus.o_count_end), 32'd0);
            chk_value("mid_rst_div3_clk",  32'(bus.o_div3_clk),  32'd0);
            k = 0;
        end
        @(negedge clk);
        #0.3;
    endtask

    initial begin
        int per_t, high_t;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        while (!mid_ok(k + 1)) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b0);
        #0.5 mon_on = 1'b0;
        #2;
        chk_value("sb_drain", 32'(sb_q.size()), 32'd0);

        per_t  = int'((t_rise - t_rise_prev) * 10.0);
        high_t = (t_fall > t_rise) ? int'((t_fall - t_rise) * 10.0)
                                   : int'((t_fall - t_rise_prev) * 10.0);
        chk_value("div3_period_x10ns", 32'(per_t),  32'd60);
        chk_value("div3_high_x10ns",   32'(high_t), 32'(HIGH_TENTHS));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
